fnd_scan_ctrl: RTL

Time-multiplexed scan controller for the stopwatch's 4-digit common-anode FND. It takes a 16-bit packed BCD value and cycles through the four digits. Each cycle it presents one nibble on `o_bcd` to the downstream BCD-to-7-segment decoder and drives the matching active-low digit common. A dead-time phase between digits suppresses ghosting. The value is snapshotted once per frame so a digit never shows a torn update.

---
 rtl/fnd_pkg.sv | 19 +
 rtl/fnd_slot_counter.sv | 43 ++++
 rtl/fnd_scan_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// fnd_pkg: shared state type and constants for the FND scan controller.
package fnd_pkg;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;

    localparam logic [NUM_DIGITS-1:0] COM_OFF = 4'b1111;

    // Active-low common pattern that lights exactly the given digit.
    function automatic logic [NUM_DIGITS-1:0] digitCom(input logic [DIGIT_W-1:0] digit);
        return ~(NUM_DIGITS'(1) << digit);
    endfunction

endpackage

// File: rtl/fnd_slot_counter.sv
// fnd_slot_counter: owns the per-slot cycle counter and the digit index.
// o_slot_end marks the last cycle of a slot; o_on_phase marks the last
// dead-time cycle, so the edge that follows it enters the on-phase.
module fnd_slot_counter
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    output logic [DIGIT_W-1:0] o_digit,
    output logic [DIGIT_W-1:0] o_digit_next,
    output logic               o_slot_end,
    output logic               o_on_phase
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DEAD_END = CNT_W'(DEAD_CYCLES - 1);

    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT_W-1:0] r_digit;

    assign o_slot_end   = (r_cnt == CNT_LAST);
    assign o_on_phase   = (r_cnt == CNT_DEAD_END);
    assign o_digit      = r_digit;
    assign o_digit_next = r_digit + DIGIT_W'(1);

    // Count cycles within a slot and step to the next digit at slot end.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_digit <= '0;
        end else if (o_slot_end) begin
            r_cnt   <= '0;
            r_digit <= o_digit_next;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: time-multiplexed scan controller for a 4-digit
// common-anode FND. Each slot starts with a dead-time phase (all commons
// off) followed by an on-phase for the current digit. The displayed value
// is snapshotted once per frame so no digit shows a torn update.
// Build option: define FND_LZB_EN to blank leading zero digits (3..1).
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV    = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [15:0] i_value,
    input  logic [3:0]  i_dp,
    input  logic        i_enable,
    output logic [3:0]  o_bcd,
    output logic        o_dp_n,
    output logic [3:0]  o_fnd_com,
    output logic [1:0]  o_digit
);

    logic               w_slotEnd;
    logic               w_onPhase;
    logic               w_frameWrap;
    logic [DIGIT_W-1:0] w_digit;
    logic [DIGIT_W-1:0] w_digitNext;

    scan_state_t        r_state;
    scan_state_t        w_stateNext;

    logic [15:0]        r_snapValue;
    logic [3:0]         r_snapDp;

    logic [3:0]         r_bcd;
    logic [3:0]         w_bcdNext;
    logic               r_dpN;
    logic               w_dpNNext;
    logic [3:0]         r_com;
    logic [3:0]         w_comNext;

    logic               w_lzbMask;
    logic               w_mask;

    fnd_slot_counter #(
        .SCAN_DIV    (SCAN_DIV),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_slotCounter (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .o_digit      (w_digit),
        .o_digit_next (w_digitNext),
        .o_slot_end   (w_slotEnd),
        .o_on_phase   (w_onPhase)
    );

    assign w_frameWrap = w_slotEnd && (w_digitNext == '0);

`ifdef FND_LZB_EN
    // Blank digit k when it and every higher snapshot nibble are zero; digit 0 always shows.
    always_comb begin
        w_lzbMask = 1'b0;
        case (w_digit)
            2'd3:    w_lzbMask = (r_snapValue[15:12] == 4'h0);
            2'd2:    w_lzbMask = (r_snapValue[15:8]  == 8'h0);
            2'd1:    w_lzbMask = (r_snapValue[15:4]  == 12'h0);
            default: w_lzbMask = 1'b0;
        endcase
    end
`else
    assign w_lzbMask = 1'b0;
`endif

    assign w_mask = !i_enable || w_lzbMask;

    // Scan state register: dead-time versus on-phase of the current slot.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= S_DEAD;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next scan state and the common pattern that goes with it.
    always_comb begin
        w_stateNext = r_state;
        w_comNext   = COM_OFF;
        if (w_slotEnd) begin
            w_stateNext = S_DEAD;
        end else if (w_onPhase) begin
            w_stateNext = S_ON;
        end
        if ((w_stateNext == S_ON) && !w_mask) begin
            w_comNext = digitCom(w_digit);
        end
    end

    // Pick the next digit's nibble and dp at slot end; digit 0 bypasses the stale snapshot.
    always_comb begin
        w_bcdNext = r_bcd;
        w_dpNNext = r_dpN;
        if (w_frameWrap) begin
            w_bcdNext = i_value[3:0];
            w_dpNNext = ~i_dp[0];
        end else if (w_slotEnd) begin
            w_bcdNext = r_snapValue[{w_digitNext, 2'b00} +: 4];
            w_dpNNext = ~r_snapDp[w_digitNext];
        end
    end

    // Capture the value and dp requests once per frame, on the 3->0 wrap.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_snapValue <= '0;
            r_snapDp    <= '0;
        end else if (w_frameWrap) begin
            r_snapValue <= i_value;
            r_snapDp    <= i_dp;
        end
    end

    // Register every display output so the pins never glitch.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bcd <= 4'h0;
            r_dpN <= 1'b1;
            r_com <= COM_OFF;
        end else begin
            r_bcd <= w_bcdNext;
            r_dpN <= w_dpNNext;
            r_com <= w_comNext;
        end
    end

    assign o_bcd     = r_bcd;
    assign o_dp_n    = r_dpN;
    assign o_fnd_com = r_com;
    assign o_digit   = w_digit;

endmodule
